// File: rtl/fifo_push_arbiter_pkg.sv
// Shared types and helpers for the FIFO push-side arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_e;

    // Cyclic increment of a producer index; wraps explicitly so NUM_REQ need not be a power of 2.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned num_req);
        return (ptr + 1 >= num_req) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_push_arbiter_if.sv
// Producer/FIFO-facing signal bundle of the push arbiter.
interface fifo_push_arbiter_if #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned LOG_NUM_REQ = $clog2(NUM_REQ)
);
    logic                                 flush_i;
    logic [NUM_REQ-1:0]                   req_valid_i;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_dat_i;
    logic [NUM_REQ-1:0]                   req_ready_o;
    logic                                 fifo_full_i;
    logic                                 fifo_push_o;
    logic [DATA_WIDTH-1:0]                fifo_dat_o;
    logic                                 fifo_flush_o;
    logic                                 grant_vld_o;
    logic [LOG_NUM_REQ-1:0]               grant_idx_o;

    // Producers, FIFO status and control drive the arbiter.
    modport master (
        output flush_i, req_valid_i, req_dat_i, fifo_full_i,
        input  req_ready_o, fifo_push_o, fifo_dat_o, fifo_flush_o, grant_vld_o, grant_idx_o
    );

    modport slave (
        input  flush_i, req_valid_i, req_dat_i, fifo_full_i,
        output req_ready_o, fifo_push_o, fifo_dat_o, fifo_flush_o, grant_vld_o, grant_idx_o
    );

endinterface

// File: rtl/fifo_push_arbiter_dffr.sv
// Plain register with asynchronous active-high reset to a parameterised value.
module dffr #(
    parameter int unsigned       WIDTH   = 1,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_q <= RST_VAL;
        end else begin
            o_q <= i_d;
        end
    end

endmodule

// File: rtl/fifo_push_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or after the pointer, cyclically.
module rr_pick #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned LOG_NUM_REQ = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]     i_req,
    input  logic [LOG_NUM_REQ-1:0] i_ptr,
    output logic [LOG_NUM_REQ-1:0] o_idx,
    output logic                   o_any
);

    int unsigned            w_cand;
    logic [LOG_NUM_REQ-1:0] w_sel;

    // Scan from the farthest offset down so the nearest hit overwrites earlier ones.
    always_comb begin
        o_idx  = '0;
        o_any  = 1'b0;
        w_cand = 0;
        w_sel  = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            w_cand = int'(i_ptr) + i;
            if (w_cand >= NUM_REQ) begin
                w_cand = w_cand - NUM_REQ;
            end
            w_sel = LOG_NUM_REQ'(w_cand);
            if (i_req[w_sel]) begin
                o_idx = w_sel;
                o_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one FIFO push port among NUM_REQ producers, with bounded bursts.
module fifo_push_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MAX_BURST   = 4,
    parameter int unsigned LOG_NUM_REQ = $clog2(NUM_REQ)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    fifo_push_arbiter_if.slave   arb_if
);

    localparam int unsigned BEAT_W = $clog2(MAX_BURST + 1);

    logic                   r_state;
    logic [LOG_NUM_REQ-1:0] r_rr_ptr;
    logic [LOG_NUM_REQ-1:0] r_gnt;
    logic [BEAT_W-1:0]      r_beat_cnt;

    arb_state_e             w_state;
    arb_state_e             w_state_d;
    logic [LOG_NUM_REQ-1:0] w_rr_ptr_d;
    logic [LOG_NUM_REQ-1:0] w_gnt_d;
    logic [BEAT_W-1:0]      w_beat_cnt_d;

    logic [LOG_NUM_REQ-1:0] w_win;
    logic                   w_any;
    logic                   w_burst;
    logic                   w_gnt_valid;
    logic                   w_open;
    logic                   w_accept;
    logic [BEAT_W-1:0]      w_beat_inc;
    logic                   w_last;
    logic [LOG_NUM_REQ-1:0] w_rr_after;
    logic [DATA_WIDTH-1:0]  w_dat;

    rr_pick #(
        .NUM_REQ     (NUM_REQ),
        .LOG_NUM_REQ (LOG_NUM_REQ)
    ) u_rr_pick (
        .i_req (arb_if.req_valid_i),
        .i_ptr (r_rr_ptr),
        .o_idx (w_win),
        .o_any (w_any)
    );

    assign w_state     = arb_state_e'(r_state);
    assign w_burst     = (w_state == ARB_BURST);
    assign w_gnt_valid = arb_if.req_valid_i[r_gnt];
    // Granted slot is open to a beat unless the FIFO is full or a flush is in progress.
    assign w_open      = w_burst & ~arb_if.fifo_full_i & ~arb_if.flush_i;
    assign w_accept    = w_open & w_gnt_valid;
    assign w_beat_inc  = r_beat_cnt + 1'b1;
    assign w_last      = (w_beat_inc == BEAT_W'(MAX_BURST));
    assign w_rr_after  = LOG_NUM_REQ'(rr_next(int'(r_gnt), NUM_REQ));

    always_comb begin
        w_state_d    = w_state;
        w_rr_ptr_d   = r_rr_ptr;
        w_gnt_d      = r_gnt;
        w_beat_cnt_d = r_beat_cnt;
        if (arb_if.flush_i) begin
            w_state_d    = ARB_IDLE;
            w_rr_ptr_d   = '0;
            w_beat_cnt_d = '0;
        end else begin
            unique case (w_state)
                ARB_IDLE: begin
                    if (w_any) begin
                        w_state_d    = ARB_BURST;
                        w_gnt_d      = w_win;
                        w_beat_cnt_d = '0;
                    end
                end
                ARB_BURST: begin
                    if (!w_gnt_valid) begin
                        w_state_d  = ARB_IDLE;
                        w_rr_ptr_d = w_rr_after;
                    end else if (w_accept) begin
                        w_beat_cnt_d = w_beat_inc;
                        if (w_last) begin
                            w_state_d  = ARB_IDLE;
                            w_rr_ptr_d = w_rr_after;
                        end
                    end
                end
            endcase
        end
    end

    dffr #(.WIDTH(1), .RST_VAL(1'b0)) u_state_q (
        .i_clk (clk_i),
        .i_rst (rst_i),
        .i_d   (1'(w_state_d)),
        .o_q   (r_state)
    );

    dffr #(.WIDTH(LOG_NUM_REQ), .RST_VAL('0)) u_rr_ptr_q (
        .i_clk (clk_i),
        .i_rst (rst_i),
        .i_d   (w_rr_ptr_d),
        .o_q   (r_rr_ptr)
    );

    dffr #(.WIDTH(LOG_NUM_REQ), .RST_VAL('0)) u_gnt_q (
        .i_clk (clk_i),
        .i_rst (rst_i),
        .i_d   (w_gnt_d),
        .o_q   (r_gnt)
    );

    dffr #(.WIDTH(BEAT_W), .RST_VAL('0)) u_beat_cnt_q (
        .i_clk (clk_i),
        .i_rst (rst_i),
        .i_d   (w_beat_cnt_d),
        .o_q   (r_beat_cnt)
    );

    always_comb begin
        arb_if.req_ready_o = '0;
        if (w_open) begin
            arb_if.req_ready_o[r_gnt] = 1'b1;
        end
    end

    assign w_dat               = arb_if.req_dat_i[r_gnt];
    assign arb_if.fifo_dat_o   = w_dat;
    assign arb_if.fifo_push_o  = w_accept;
    assign arb_if.fifo_flush_o = arb_if.flush_i;
    assign arb_if.grant_vld_o  = w_burst;
    assign arb_if.grant_idx_o  = r_gnt;

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed scenarios with a scoreboard of expected (producer, data) pushes in FIFO order.
module tb_fifo_push_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 32;

    typedef struct {
        int unsigned   idx;
        logic [DW-1:0] dat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    exp_t        exp_q[$];
    int unsigned rem[NR];
    int unsigned bidx[NR];
    logic [NR-1:0] acc;

    int n_cmp = 0;
    int n_err = 0;

    fifo_push_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    fifo_push_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .MAX_BURST  (4)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .arb_if (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mk(input int unsigned p, input int unsigned k);
        return DW'(p * 65536 + k);
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic load(input int unsigned p, input int unsigned n, input int unsigned base);
        rem[p]  = n;
        bidx[p] = base;
    endtask

    task automatic expect_beats(input int unsigned p, input int unsigned base, input int unsigned n);
        for (int k = 0; k < int'(n); k++) begin
            exp_q.push_back('{idx: p, dat: mk(p, base + k)});
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #3;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && rem[0] == 0 && rem[1] == 0 && rem[2] == 0 && rem[3] == 0
                && !bus.grant_vld_o) begin
                done = 1'b1;
                break;
            end
        end
        chk(name, DW'(done), DW'(1));
    endtask

    // Producers present beats while they have any left; data encodes producer and beat index.
    always_comb begin
        for (int p = 0; p < int'(NR); p++) begin
            bus.req_valid_i[p] = (rem[p] != 0);
            bus.req_dat_i[p]   = mk(p, bidx[p]);
        end
    end

    always begin
        @(negedge clk);
        acc = bus.req_valid_i & bus.req_ready_o;
        @(posedge clk);
        #1;
        for (int p = 0; p < int'(NR); p++) begin
            if (acc[p]) begin
                rem[p]  = rem[p] - 1;
                bidx[p] = bidx[p] + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (bus.fifo_push_o) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_push: got data 0x%0h idx %0d, expected no push at %0t",
                         bus.fifo_dat_o, bus.grant_idx_o, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("push_dat", bus.fifo_dat_o, e.dat);
                chk("push_idx", DW'(bus.grant_idx_o), DW'(e.idx));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int p = 0; p < int'(NR); p++) begin
            rem[p]  = 0;
            bidx[p] = 0;
        end
        bus.flush_i     = 1'b0;
        bus.fifo_full_i = 1'b0;
        repeat (3) @(posedge clk);
        at_neg();
        chk("rst_ready", DW'(bus.req_ready_o), DW'(0));
        chk("rst_push", DW'(bus.fifo_push_o), DW'(0));
        chk("rst_gvld", DW'(bus.grant_vld_o), DW'(0));
        chk("rst_gidx", DW'(bus.grant_idx_o), DW'(0));
        chk("rst_dat", bus.fifo_dat_o, mk(0, 0));
        sync();
        rst = 1'b0;

        // Single producer, 3 beats, voluntary release.
        sync();
        load(0, 3, 'hA);
        expect_beats(0, 'hA, 3);
        at_neg();
        chk("t1_lat_ready", DW'(bus.req_ready_o), DW'(0));
        chk("t1_lat_gvld", DW'(bus.grant_vld_o), DW'(0));
        at_neg();
        chk("t1_gvld", DW'(bus.grant_vld_o), DW'(1));
        chk("t1_ready", DW'(bus.req_ready_o), DW'(4'b0001));
        at_neg();
        at_neg();
        at_neg();
        chk("t1_rel_gvld", DW'(bus.grant_vld_o), DW'(1));
        chk("t1_rel_push", DW'(bus.fifo_push_o), DW'(0));
        chk("t1_rel_ready", DW'(bus.req_ready_o), DW'(4'b0001));
        at_neg();
        chk("t1_end_gvld", DW'(bus.grant_vld_o), DW'(0));
        drain("t1_drain");

        // rr_ptr=1: producer 3 wins over 0, then the pointer wraps to 0.
        sync();
        load(3, 4, 'h50);
        load(0, 4, 'h60);
        expect_beats(3, 'h50, 4);
        expect_beats(0, 'h60, 4);
        @(posedge clk);
        at_neg();
        chk("t5_first_idx", DW'(bus.grant_idx_o), DW'(3));
        drain("t5_drain");

        // Flush on beat 2 of producer 1's burst.
        sync();
        load(0, 4, 'h100);
        load(1, 2, 'h110);
        load(2, 4, 'h120);
        load(3, 4, 'h130);
        expect_beats(1, 'h110, 1);
        expect_beats(0, 'h100, 4);
        expect_beats(1, 'h111, 1);
        expect_beats(2, 'h120, 4);
        expect_beats(3, 'h130, 4);
        @(posedge clk);
        at_neg();
        chk("t4_gidx", DW'(bus.grant_idx_o), DW'(1));
        sync();
        bus.flush_i = 1'b1;
        #1;
        chk("t4_flush_o", DW'(bus.fifo_flush_o), DW'(1));
        chk("t4_push", DW'(bus.fifo_push_o), DW'(0));
        chk("t4_ready", DW'(bus.req_ready_o), DW'(0));
        sync();
        bus.flush_i = 1'b0;
        at_neg();
        chk("t4_idle", DW'(bus.grant_vld_o), DW'(0));
        at_neg();
        chk("t4_regrant_vld", DW'(bus.grant_vld_o), DW'(1));
        chk("t4_regrant_idx", DW'(bus.grant_idx_o), DW'(0));
        drain("t4_drain");

        // All producers valid: bursts of exactly 4 with one idle bubble, order 0,1,2,3,0.
        sync();
        for (int p = 0; p < int'(NR); p++) begin
            load(p, 5, 'h200 + p * 16);
        end
        for (int p = 0; p < int'(NR); p++) begin
            expect_beats(p, 'h200 + p * 16, 4);
        end
        for (int p = 0; p < int'(NR); p++) begin
            expect_beats(p, 'h204 + p * 16, 1);
        end
        at_neg();
        for (int b = 0; b < int'(NR); b++) begin
            for (int k = 0; k < 4; k++) begin
                at_neg();
                chk("t2_push", DW'(bus.fifo_push_o), DW'(1));
                chk("t2_gidx", DW'(bus.grant_idx_o), DW'(b));
            end
            at_neg();
            chk("t2_bubble_gvld", DW'(bus.grant_vld_o), DW'(0));
            chk("t2_bubble_push", DW'(bus.fifo_push_o), DW'(0));
        end
        at_neg();
        chk("t2_wrap_idx", DW'(bus.grant_idx_o), DW'(0));
        drain("t2_drain");

        // Producer 2 stalled by full for 5 cycles after its first beat.
        sync();
        load(2, 5, 'h300);
        expect_beats(2, 'h300, 5);
        @(posedge clk);
        at_neg();
        chk("t3_gidx", DW'(bus.grant_idx_o), DW'(2));
        sync();
        bus.fifo_full_i = 1'b1;
        repeat (5) begin
            at_neg();
            chk("t3_full_push", DW'(bus.fifo_push_o), DW'(0));
            chk("t3_full_ready", DW'(bus.req_ready_o), DW'(0));
            chk("t3_full_gvld", DW'(bus.grant_vld_o), DW'(1));
        end
        sync();
        bus.fifo_full_i = 1'b0;
        repeat (3) begin
            at_neg();
            chk("t3_resume_push", DW'(bus.fifo_push_o), DW'(1));
        end
        at_neg();
        chk("t3_end_gvld", DW'(bus.grant_vld_o), DW'(0));
        drain("t3_drain");

        // Reset mid-burst while producer 3 has valid and ready high.
        sync();
        load(3, 4, 'h400);
        expect_beats(3, 'h400, 1);
        @(posedge clk);
        at_neg();
        chk("t6_gidx", DW'(bus.grant_idx_o), DW'(3));
        sync();
        chk("t6_pre_push", DW'(bus.fifo_push_o), DW'(1));
        rst = 1'b1;
        load(0, 2, 'h410);
        load(1, 2, 'h420);
        #1;
        chk("t6_rst_push", DW'(bus.fifo_push_o), DW'(0));
        chk("t6_rst_ready", DW'(bus.req_ready_o), DW'(0));
        chk("t6_rst_gvld", DW'(bus.grant_vld_o), DW'(0));
        chk("t6_rst_gidx", DW'(bus.grant_idx_o), DW'(0));
        expect_beats(0, 'h410, 2);
        expect_beats(1, 'h420, 2);
        expect_beats(3, 'h401, 3);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        at_neg();
        chk("t6_first_vld", DW'(bus.grant_vld_o), DW'(1));
        chk("t6_first_idx", DW'(bus.grant_idx_o), DW'(0));
        drain("t6_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
